// File: rtl/byte_word_assembler.sv
// Packs a valid/ready byte stream into words with a per-lane enable mask,
// a per-word sticky parity-error flag and an early close on byte_last.
//
// state   | meaning
// COLLECT | filling lanes of the partial word, word_valid_o=0
// HOLD    | completed word presented, word_valid_o=1 until word_ready_i
module byte_word_assembler #(
    parameter int BYTES_PER_WORD = 4,
    parameter bit MSB_FIRST      = 1'b0,
    localparam int DW = 8 * BYTES_PER_WORD,
    localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic [7:0]                byte_data_i,
    input  logic                      byte_parity_i,
    input  logic                      byte_last_i,
    input  logic                      byte_valid_i,
    output logic                      byte_ready_o,
    output logic [DW-1:0]             word_data_o,
    output logic [BYTES_PER_WORD-1:0] word_byte_en_o,
    output logic                      word_parity_err_o,
    output logic                      word_last_o,
    output logic                      word_valid_o,
    input  logic                      word_ready_i,
    output logic [IW-1:0]             byte_index_o
);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t                    state_q;
    logic [IW-1:0]             idx_q;
    logic [DW-1:0]             acc_data_q, acc_data_d;
    logic [BYTES_PER_WORD-1:0] acc_en_q, acc_en_d;
    logic                      acc_err_q, acc_err_d;
    logic [DW-1:0]             word_data_q;
    logic [BYTES_PER_WORD-1:0] word_en_q;
    logic                      word_err_q, word_last_q;
    logic [IW-1:0]             lane;
    logic                      accept, close;

    always_comb begin
        byte_ready_o = (state_q == COLLECT) || word_ready_i;
        accept       = byte_valid_i && byte_ready_o;
        lane         = MSB_FIRST ? (IW'(BYTES_PER_WORD - 1) - idx_q) : idx_q;
        acc_data_d   = acc_data_q;
        acc_en_d     = acc_en_q;
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
            if (lane == IW'(l)) begin
                acc_data_d[8*l +: 8] = byte_data_i;
                acc_en_d[l]          = 1'b1;
            end
        end
        acc_err_d = acc_err_q | (byte_parity_i != ^byte_data_i);
        close     = accept && (byte_last_i || (idx_q == IW'(BYTES_PER_WORD - 1)));
    end

    // The accumulator is always empty in HOLD (a close clears it), so a byte
    // taken on the consuming cycle naturally lands in lane 0 of the next word.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            acc_data_q  <= '0;
            acc_en_q    <= '0;
            acc_err_q   <= 1'b0;
            word_data_q <= '0;
            word_en_q   <= '0;
            word_err_q  <= 1'b0;
            word_last_q <= 1'b0;
        end else if (close) begin
            state_q     <= HOLD;
            word_data_q <= acc_data_d;
            word_en_q   <= acc_en_d;
            word_err_q  <= acc_err_d;
            word_last_q <= byte_last_i;
            idx_q       <= '0;
            acc_data_q  <= '0;
            acc_en_q    <= '0;
            acc_err_q   <= 1'b0;
        end else begin
            if (state_q == HOLD && word_ready_i) begin
                state_q <= COLLECT;
            end
            if (accept) begin
                acc_data_q <= acc_data_d;
                acc_en_q   <= acc_en_d;
                acc_err_q  <= acc_err_d;
                idx_q      <= idx_q + IW'(1);
            end
        end
    end

    assign word_valid_o      = (state_q == HOLD);
    assign word_data_o       = word_data_q;
    assign word_byte_en_o    = word_en_q;
    assign word_parity_err_o = word_err_q;
    assign word_last_o       = word_last_q;
    assign byte_index_o      = idx_q;

endmodule

// File: tb/tb_byte_word_assembler.sv
// Directed bench for byte_word_assembler: LSB-first and MSB-first instances
// share one stimulus stream and are checked against a queue-based word model.
module tb_byte_word_assembler;

    localparam int BPW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_data;
    logic        byte_parity, byte_last, byte_valid, word_ready;

    logic        rdy0, rdy1, val0, val1, err0, err1, last0, last1;
    logic [31:0] data0, data1;
    logic [3:0]  en0, en1;
    logic [1:0]  idx0, idx1;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    byte_word_assembler #(.BYTES_PER_WORD(BPW), .MSB_FIRST(1'b0)) u_lsb (
        .clock_i(clk), .reset_n_i(rst_n),
        .byte_data_i(byte_data), .byte_parity_i(byte_parity),
        .byte_last_i(byte_last), .byte_valid_i(byte_valid), .byte_ready_o(rdy0),
        .word_data_o(data0), .word_byte_en_o(en0), .word_parity_err_o(err0),
        .word_last_o(last0), .word_valid_o(val0), .word_ready_i(word_ready),
        .byte_index_o(idx0));

    byte_word_assembler #(.BYTES_PER_WORD(BPW), .MSB_FIRST(1'b1)) u_msb (
        .clock_i(clk), .reset_n_i(rst_n),
        .byte_data_i(byte_data), .byte_parity_i(byte_parity),
        .byte_last_i(byte_last), .byte_valid_i(byte_valid), .byte_ready_o(rdy1),
        .word_data_o(data1), .word_byte_en_o(en1), .word_parity_err_o(err1),
        .word_last_o(last1), .word_valid_o(val1), .word_ready_i(word_ready),
        .byte_index_o(idx1));

    // Model: bytes of the open word in a queue; a finished word is built from it.
    bit [7:0]  m_q[$];
    bit        m_err;
    bit        m_valid, m_last, m_perr;
    bit [31:0] m_d0, m_d1;
    bit [3:0]  m_e0, m_e1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_err   = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_perr  = 1'b0;
            m_d0    = '0;
            m_d1    = '0;
            m_e0    = '0;
            m_e1    = '0;
        end else begin
            bit acc;
            acc = byte_valid && (!m_valid || word_ready);
            if (m_valid && word_ready) m_valid = 1'b0;
            if (acc) begin
                m_q.push_back(byte_data);
                if (byte_parity != ^byte_data) m_err = 1'b1;
                if (m_q.size() == BPW || byte_last) begin
                    int n, msk;
                    n    = m_q.size();
                    m_d0 = '0;
                    m_d1 = '0;
                    for (int i = 0; i < n; i++) begin
                        m_d0 = m_d0 | (32'(m_q[i]) << (8 * i));
                        m_d1 = m_d1 | (32'(m_q[i]) << (8 * (BPW - 1 - i)));
                    end
                    msk     = (1 << n) - 1;
                    m_e0    = 4'(msk);
                    m_e1    = 4'(msk << (BPW - n));
                    m_perr  = m_err;
                    m_last  = byte_last;
                    m_valid = 1'b1;
                    m_q.delete();
                    m_err   = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && rst_n) begin
            chk("cyc_valid0", 32'(val0), 32'(m_valid));
            chk("cyc_valid1", 32'(val1), 32'(m_valid));
            chk("cyc_ready0", 32'(rdy0), 32'(!m_valid || word_ready));
            chk("cyc_ready1", 32'(rdy1), 32'(!m_valid || word_ready));
            chk("cyc_index0", 32'(idx0), 32'(m_q.size()));
            chk("cyc_index1", 32'(idx1), 32'(m_q.size()));
            if (m_valid) begin
                chk("cyc_data0", data0, m_d0);
                chk("cyc_data1", data1, m_d1);
                chk("cyc_en0", 32'(en0), 32'(m_e0));
                chk("cyc_en1", 32'(en1), 32'(m_e1));
                chk("cyc_err0", 32'(err0), 32'(m_perr));
                chk("cyc_err1", 32'(err1), 32'(m_perr));
                chk("cyc_last0", 32'(last0), 32'(m_last));
                chk("cyc_last1", 32'(last1), 32'(m_last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit last, input bit badp);
        byte_data   = d;
        byte_parity = (^d) ^ badp;
        byte_last   = last;
        byte_valid  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            bit acc;
            acc = !m_valid || word_ready;
            step();
            if (acc) begin
                byte_valid = 1'b0;
                byte_last  = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: byte %h not accepted in 20 cycles", d);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic chk_word(input string name, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [3:0] e0, input logic [3:0] e1,
                            input bit err, input bit last);
        chk({name, "_valid"}, 32'(val0), 32'd1);
        chk({name, "_data_lsb"}, data0, d0);
        chk({name, "_data_msb"}, data1, d1);
        chk({name, "_en_lsb"}, 32'(en0), 32'(e0));
        chk({name, "_en_msb"}, 32'(en1), 32'(e1));
        chk({name, "_err"}, 32'(err0), 32'(err));
        chk({name, "_last"}, 32'(last0), 32'(last));
    endtask

    initial begin
        rst_n       = 1'b0;
        byte_data   = '0;
        byte_parity = 1'b0;
        byte_last   = 1'b0;
        byte_valid  = 1'b0;
        word_ready  = 1'b0;
        step();
        chk("rst_valid", 32'(val0), 32'd0);
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_index", 32'(idx0), 32'd0);
        chk("rst_data", data0, 32'd0);
        chk("rst_en", 32'(en0), 32'd0);
        step();
        rst_n   = 1'b1;
        started = 1'b1;
        step();

        // 1/2: full word, both lane orders
        word_ready = 1'b1;
        send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h44, 0, 0);
        chk_word("t1", 32'h44332211, 32'h11223344, 4'hF, 4'hF, 0, 0);
        step();
        chk("t1_valid_one_cycle", 32'(val0), 32'd0);

        // 3: early close on byte_last, next word restarts at lane 0
        send(8'hAA, 0, 0); send(8'hBB, 1, 0);
        chk_word("t3", 32'h0000BBAA, 32'hAABB0000, 4'h3, 4'hC, 0, 1);
        chk("t3_index", 32'(idx0), 32'd0);
        step();

        // 4: parity error is sticky in its word and cleared for the next
        send(8'h03, 0, 1); send(8'h04, 0, 0); send(8'h05, 0, 0); send(8'h06, 0, 0);
        chk_word("t4a", 32'h06050403, 32'h03040506, 4'hF, 4'hF, 1, 0);
        send(8'h07, 0, 0); send(8'h08, 0, 0); send(8'h09, 0, 0); send(8'h0A, 0, 0);
        chk_word("t4b", 32'h0A090807, 32'h0708090A, 4'hF, 4'hF, 0, 0);
        step();

        // 5: backpressure, then zero-bubble release with 55 pending
        word_ready = 1'b0;
        send(8'h21, 0, 0); send(8'h22, 0, 0); send(8'h23, 0, 0); send(8'h24, 0, 0);
        byte_data   = 8'h55;
        byte_parity = ^byte_data;
        byte_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_word("t5_hold", 32'h24232221, 32'h21222324, 4'hF, 4'hF, 0, 0);
            chk("t5_ready", 32'(rdy0), 32'd0);
            step();
        end
        word_ready = 1'b1;
        step();
        byte_valid = 1'b0;
        chk("t5_released", 32'(val0), 32'd0);
        chk("t5_index", 32'(idx0), 32'd1);
        send(8'h56, 0, 0); send(8'h57, 0, 0); send(8'h58, 0, 0);
        chk_word("t5_next", 32'h58575655, 32'h55565758, 4'hF, 4'hF, 0, 0);

        // zero-bubble single-byte last word while a word is held
        word_ready = 1'b0;
        step();
        byte_data   = 8'h77;
        byte_parity = ^byte_data;
        byte_last   = 1'b1;
        byte_valid  = 1'b1;
        step();
        word_ready = 1'b1;
        step();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        chk_word("t5_last1", 32'h00000077, 32'h77000000, 4'h1, 4'h8, 0, 1);
        step();

        // 6: reset mid-word discards the partial word
        send(8'h31, 0, 0); send(8'h32, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(val0), 32'd0);
        chk("t6_rst_index", 32'(idx0), 32'd0);
        chk("t6_rst_ready", 32'(rdy0), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_no_word", 32'(val0), 32'd0);
        send(8'h41, 0, 0); send(8'h42, 0, 0); send(8'h43, 0, 0); send(8'h44, 0, 0);
        chk_word("t6", 32'h44434241, 32'h41424344, 4'hF, 4'hF, 0, 0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
